mem_port_arbiter: RTL

//  Shares the single physical memory port between the instruction-fetch requester (I) and the data

---
 rtl/lc3b_types.sv | 43 ++++
 rtl/arb_cmd_reg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory-port arbiter: command struct, FSM states and a
// command-building helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
  } mem_cmd_t;

  // A requester asserting both read and write is treated as a write.
  function automatic mem_cmd_t make_cmd(input logic          read,
                                        input logic          write,
                                        input lc3b_word      address,
                                        input lc3b_word      wdata,
                                        input lc3b_mem_wmask byte_enable);
    mem_cmd_t cmd;
    cmd.read        = read & ~write;
    cmd.write       = write;
    cmd.address     = address;
    cmd.wdata       = wdata;
    cmd.byte_enable = byte_enable;
    return cmd;
  endfunction

endpackage

// File: rtl/arb_cmd_reg.sv
// Loadable memory-command register; a strobe-clear drops read/write while keeping
// address, data and byte mask.
module arb_cmd_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     strobe_clr,
  input  mem_cmd_t cmd_d,
  output mem_cmd_t cmd_q
);

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (load) begin
      cmd_q <= cmd_d;
    end else if (strobe_clr) begin
      cmd_q.read  <= 1'b0;
      cmd_q.write <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction / data) arbiter for the single memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default gives D fixed priority.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [15:0]      i_mem_address,
  input  logic [15:0]      i_mem_wdata,
  input  logic [1:0]       i_mem_byte_enable,
  output logic             i_mem_resp,
  output logic [15:0]      i_mem_rdata,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic [15:0]      d_mem_address,
  input  logic [15:0]      d_mem_wdata,
  input  logic [1:0]       d_mem_byte_enable,
  output logic             d_mem_resp,
  output logic [15:0]      d_mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_address,
  output logic [15:0]      mem_wdata,
  output logic [1:0]       mem_byte_enable,
  input  logic             mem_resp,
  input  logic [15:0]      mem_rdata,
  output logic [CNT_W-1:0] i_count,
  output logic [CNT_W-1:0] d_count
);

  arb_state_t state, state_nxt;
  arb_side_t  last_grant;
  mem_cmd_t   cmd_d, cmd_q;
  logic       i_pend, d_pend, grant_d, load, done_i, done_d;

  assign i_pend = i_mem_read | i_mem_write;
  assign d_pend = d_mem_read | d_mem_write;

  // Winner is only meaningful in IDLE; elsewhere it is ignored.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (i_pend && d_pend) grant_d = (last_grant == SIDE_I);
    else                  grant_d = d_pend;
`else
    grant_d = d_pend;
`endif
  end

  assign load   = (state == IDLE) && (i_pend || d_pend);
  assign cmd_d  = grant_d
                ? make_cmd(d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable)
                : make_cmd(i_mem_read, i_mem_write, i_mem_address, i_mem_wdata, i_mem_byte_enable);
  assign done_i = (state == GNT_I) && mem_resp;
  assign done_d = (state == GNT_D) && mem_resp;

  arb_cmd_reg u_cmd_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .strobe_clr (done_i | done_d),
    .cmd_d      (cmd_d),
    .cmd_q      (cmd_q)
  );

  // NOTE: next-state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = grant_d ? GNT_D : GNT_I;
      GNT_I:   if (mem_resp) state_nxt = GAP;
      GNT_D:   if (mem_resp) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
      i_count    <= '0;
      d_count    <= '0;
    end else begin
      state <= state_nxt;
      if (done_i) begin
        i_count    <= i_count + CNT_W'(1);
        last_grant <= SIDE_I;
      end
      if (done_d) begin
        d_count    <= d_count + CNT_W'(1);
        last_grant <= SIDE_D;
      end
    end
  end

  // Response is steered to the granted side only; read data is shared.
  assign i_mem_resp  = done_i;
  assign d_mem_resp  = done_d;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  assign mem_read        = cmd_q.read;
  assign mem_write       = cmd_q.write;
  assign mem_address     = cmd_q.address;
  assign mem_wdata       = cmd_q.wdata;
  assign mem_byte_enable = cmd_q.byte_enable;

endmodule
